// File: rtl/gpio_bank_pkg.sv
// gpio_bank shared definitions.
// Register word addresses and bus constants.
package gpio_bank_pkg;

  localparam int GPIO_NREGS = 8;
  localparam int GPIO_BUS_W = 32;

  localparam logic [31:0] GPIO_DIR      = 32'd0;
  localparam logic [31:0] GPIO_OUT      = 32'd1;
  localparam logic [31:0] GPIO_IN       = 32'd2;
  localparam logic [31:0] GPIO_INT_EN   = 32'd3;
  localparam logic [31:0] GPIO_INT_RISE = 32'd4;
  localparam logic [31:0] GPIO_STATUS   = 32'd5;
  localparam logic [31:0] GPIO_OUT_SET  = 32'd6;
  localparam logic [31:0] GPIO_OUT_CLR  = 32'd7;

endpackage

// File: rtl/gpio_sync.sv
// Multi-bit, multi-stage input synchroniser.
// Each bit is synchronised independently; no bus coherency.
module gpio_sync #(
  parameter int NPINS  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPINS-1:0] d,
  output logic [NPINS-1:0] q
);

  logic [NPINS-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: direction, set/clear outputs,
// synchronised inputs and per-pin edge interrupts.
module gpio_bank #(
  parameter int NPINS       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic              err_o,
  input  logic [NPINS-1:0]  gpio_in,
  output logic [NPINS-1:0]  gpio_out,
  output logic [NPINS-1:0]  gpio_oeb,
  output logic              irq_o
);

  import gpio_bank_pkg::*;

  logic [NPINS-1:0] dir_q;
  logic [NPINS-1:0] out_q;
  logic [NPINS-1:0] int_en_q;
  logic [NPINS-1:0] int_rise_q;
  logic [NPINS-1:0] status_q;
  logic [NPINS-1:0] status_d;
  logic [NPINS-1:0] sync_q;
  logic [NPINS-1:0] prev_q;
  logic [NPINS-1:0] edge_v;
  logic [NPINS-1:0] w1c;
  logic [NPINS-1:0] wdata_m;
  logic [NPINS-1:0] rd_val;
  logic [31:0]      addr_ext;
  logic [31:0]      rdata_q;
  logic             rvalid_q;
  logic             err_q;
  logic             irq_q;
  logic             acc_err;
  logic             wr;

  gpio_sync #(
    .NPINS  (NPINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gpio_in),
    .q     (sync_q)
  );

  assign addr_ext = 32'(addr_i);
  assign wdata_m  = wdata_i[NPINS-1:0];
  assign wr       = req_i & we_i;

  // Only the sync/prev pair feeds detection, so
  // reprogramming INT_RISE cannot fake an edge.
  assign edge_v = (sync_q & ~prev_q & int_rise_q)
                | (~sync_q & prev_q & ~int_rise_q);

  assign w1c = (wr && addr_ext == GPIO_STATUS)
             ? wdata_m : '0;

  assign status_d = (status_q & ~w1c) | edge_v;

  always_comb begin
    rd_val  = '0;
    acc_err = 1'b0;
    unique case (addr_ext)
      GPIO_DIR:      rd_val = dir_q;
      GPIO_OUT:      rd_val = out_q;
      GPIO_IN: begin
        rd_val  = sync_q;
        acc_err = we_i;
      end
      GPIO_INT_EN:   rd_val = int_en_q;
      GPIO_INT_RISE: rd_val = int_rise_q;
      GPIO_STATUS:   rd_val = status_q;
      GPIO_OUT_SET:  rd_val = '0;
      GPIO_OUT_CLR:  rd_val = '0;
      default:       acc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= '0;
      out_q      <= '0;
      int_en_q   <= '0;
      int_rise_q <= '0;
    end else if (wr) begin
      case (addr_ext)
        GPIO_DIR:      dir_q      <= wdata_m;
        GPIO_OUT:      out_q      <= wdata_m;
        GPIO_INT_EN:   int_en_q   <= wdata_m;
        GPIO_INT_RISE: int_rise_q <= wdata_m;
        GPIO_OUT_SET:  out_q      <= out_q | wdata_m;
        GPIO_OUT_CLR:  out_q      <= out_q & ~wdata_m;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      prev_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      prev_q   <= sync_q;
      irq_q    <= |(status_q & int_en_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= req_i;
      err_q    <= req_i & acc_err;
      rdata_q  <= (req_i && !we_i) ? 32'(rd_val) : '0;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign irq_o    = irq_q;
  assign gpio_out = out_q;
  assign gpio_oeb = ~dir_q;

endmodule
